add_64bit_seq: RTL and testbench
================================

// Module: add_64bit_seq
// PURPOSE
//  Multi-cycle signed two's-complement adder, the addition counterpart of the ALU subtract path.
//  Adds CHUNK bits per cycle, ripple carry held in a register; reports signed overflow and carry-out.
//  Sits behind the ALU op decode; a valid/ready handshake on each side lets the ALU stall on it.
// PARAMETERS
//  WIDTH  64  operand/result width in bits
//  CHUNK  16  bits added per RUN cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      a/b valid
//  in_ready   out  1      block accepts operands (IDLE only)
//  a          in   WIDTH  signed operand A
//  b          in   WIDTH  signed operand B
//  out_valid  out  1      sum/overflow/carry_out valid
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  signed a+b, modulo 2^WIDTH
//  overflow   out  1      signed overflow of a+b
//  carry_out  out  1      unsigned carry out of bit WIDTH-1
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, in_ready=1, out_valid=0, sum=0, overflow=0, carry_out=0,
//   chunk count=0, internal carry=0. Reset wins over any other event and aborts RUN/DONE mid-op.
//  FSM IDLE -> RUN -> DONE -> IDLE; N = WIDTH/CHUNK.
//  IDLE: in_ready=1. On edge with in_valid=1: latch a,b; carry=0; count=0; go RUN.
//   in_valid=0: stay IDLE.
//  RUN: in_ready=0, out_valid=0. Each cycle: {c,s} = a[k*CHUNK+:CHUNK] + b[k*CHUNK+:CHUNK] + carry,
//   with k=count; write s to sum[k*CHUNK+:CHUNK]; carry<=c; count<=count+1.
//   After chunk N-1: carry_out<=c; overflow<=(a[W-1]==b[W-1]) && (s[CHUNK-1]!=a[W-1]); go DONE.
//  Latency: operands accepted at edge T -> out_valid=1 after edge T+N (N RUN cycles; 4 at defaults).
//  DONE: out_valid=1, in_ready=0; sum/overflow/carry_out held stable while out_ready=0.
//   On edge with out_ready=1: go IDLE, out_valid->0. Result regs keep their value until the next accept.
//   No same-cycle re-accept: at least one IDLE cycle between results.
//  in_valid outside IDLE is ignored; a and b may change freely after the accept edge.
//  sum is undefined-but-stable (partially written) while in RUN; consumers use it only with out_valid.
//  Width: sum wraps modulo 2^WIDTH; carry_out is unsigned carry; overflow is signed only.
//  CHUNK==WIDTH is legal: N=1, single RUN cycle.
// TESTING
//  1) a=5,b=7 -> sum=12, ov=0, co=0; out_valid exactly 4 cycles after accept edge.
//  2) a=0x0000_0000_FFFF_FFFF,b=1 -> sum=0x0000_0001_0000_0000, ov=0, co=0 (inter-chunk carry).
//  3) a=0x7FFF_FFFF_FFFF_FFFF,b=1 -> sum=0x8000_0000_0000_0000, ov=1, co=0.
//  4) a=-1,b=1 -> sum=0, ov=0, co=1; a=b=0x8000_0000_0000_0000 -> sum=0, ov=1, co=1.
//  5) out_ready=0 for 5 cycles in DONE, in_valid=1 toggling a -> outputs stable, in_ready=0,
//     no new accept; out_ready=1 -> IDLE next cycle, in_ready=1.
//  6) rst=1 at 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0, ov=0, co=0;
//     new op a=-3,b=-4 -> sum=-7, ov=0, co=1.

Source files
------------

// File: rtl/add_64bit_seq.sv
// ---------------------------------------------------------------------------
// add_64bit_seq
//   Multi-cycle signed two's-complement adder. It adds CHUNK bits per cycle
//   and holds the ripple carry in a register between cycles. It reports the
//   signed overflow and the unsigned carry-out of the full-width add. Both
//   sides use a valid/ready handshake, so the ALU can stall on this block.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any op in flight)
//   in_valid   a/b valid            in_ready   operands accepted (IDLE only)
//   a, b       signed operands      out_valid  sum/overflow/carry_out valid
//   out_ready  consumer takes result
//   sum        a+b modulo 2^WIDTH
//   overflow   signed overflow      carry_out  unsigned carry out of MSB
//
// Timing
//   Operands are accepted at edge T. out_valid rises after edge T+N,
//   where N = WIDTH/CHUNK.
// ---------------------------------------------------------------------------
module add_64bit_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             carry_out
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("add_64bit_seq: WIDTH must be a multiple of CHUNK");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ov_q, ov_d;
  logic             co_q, co_d;

  logic [CHUNK-1:0] a_ch, b_ch, s_nx;
  logic             c_nx;
  logic             last;

  always_comb begin
    // Select the chunk for the current count. A loop over constant slices
    // keeps every part-select static.
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(cnt_q) == k) begin
        a_ch = a_q[k*CHUNK +: CHUNK];
        b_ch = b_q[k*CHUNK +: CHUNK];
      end
    end
    {c_nx, s_nx} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    last = (int'(cnt_q) == NCH - 1);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ov_d    = ov_q;
    co_d    = co_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NCH; k++) begin
          if (int'(cnt_q) == k) sum_d[k*CHUNK +: CHUNK] = s_nx;
        end
        carry_d = c_nx;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          co_d = c_nx;
          // Signed overflow: the operand signs match, and the result sign
          // differs from them.
          ov_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nx[CHUNK-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ov_q    <= ov_d;
      co_q    <= co_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign overflow  = ov_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_add_64bit_seq.sv
module tb_add_64bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        overflow;
  logic        carry_out;

  typedef struct packed {
    logic [63:0] sum;
    logic        ov;
    logic        co;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  add_64bit_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow), .carry_out(carry_out)
  );

  // Compute the expected result from a plain 65-bit add and push it to the
  // scoreboard. Drive the operands for one accept edge. Wait for out_valid,
  // then pop the entry and compare it. Leave the DUT in DONE.
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv, input string nm);
    exp_t        e;
    logic [64:0] full;
    int          cyc;
    full  = {1'b0, av} + {1'b0, bv};
    e.sum = full[63:0];
    e.co  = full[64];
    e.ov  = (av[63] == bv[63]) && (full[63] != av[63]);
    sb.push_back(e);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready);
    end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid never rose in %0d cycles", nm, cyc);
      void'(sb.pop_front());
      return;
    end else if (cyc != 4) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want 4", nm, cyc);
    end
    e = sb.pop_front();
    n_checks++;
    if (sum !== e.sum) begin
      n_fail++;
      $display("FAIL %s sum: got %h want %h", nm, sum, e.sum);
    end
    n_checks++;
    if (overflow !== e.ov) begin
      n_fail++;
      $display("FAIL %s overflow: got %b want %b", nm, overflow, e.ov);
    end
    n_checks++;
    if (carry_out !== e.co) begin
      n_fail++;
      $display("FAIL %s carry_out: got %b want %b", nm, carry_out, e.co);
    end
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s drain: out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (sum !== 64'd0 || overflow !== 1'b0 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: sum=%h ov=%b co=%b want 0/0/0", sum, overflow, carry_out);
    end
  endtask

  task automatic test_basic;
    do_op(64'd5, 64'd7, "small");                                    drain("small");
    do_op(64'h0000_0000_FFFF_FFFF, 64'd1, "chunk_carry");            drain("chunk_carry");
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "pos_ovf");                drain("pos_ovf");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "wrap");                   drain("wrap");
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "neg_ovf"); drain("neg_ovf");
  endtask

  task automatic test_stall;
    logic [63:0] s0;
    logic        ov0, co0;
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "stall");
    s0 = sum; ov0 = overflow; co0 = carry_out;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = (i % 2 == 0) ? 64'h1111_2222_3333_4444 : 64'hDEAD_BEEF_0000_0001;
      b = 64'd9;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== s0 ||
          overflow !== ov0 || carry_out !== co0) begin
        n_fail++;
        $display("FAIL stall hold %0d: ov=%b rdy=%b sum=%h/%b/%b want 1 0 %h/%b/%b",
                 i, out_valid, in_ready, sum, overflow, carry_out, s0, ov0, co0);
      end
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (sum !== s0) begin
      n_fail++;
      $display("FAIL stall result kept: sum=%h want %h", sum, s0);
    end
  endtask

  task automatic test_reset_midop;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1;          // accepted, first RUN cycle
    in_valid = 1'b0;
    @(posedge clk); #1;          // second RUN cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 64'd0 ||
        overflow !== 1'b0 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midop reset: rdy=%b vld=%b sum=%h ov=%b co=%b want 1 0 0 0 0",
               in_ready, out_valid, sum, overflow, carry_out);
    end
    do_op(-64'sd3, -64'sd4, "after_reset");
    drain("after_reset");
  endtask

  task automatic test_back_to_back;
    logic [63:0] av, bv;
    for (int i = 0; i < 16; i++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      if (i % 4 == 1) bv = ~av;               // all-ones sum, no carry
      if (i % 4 == 2) bv = (~av) + 64'd1;     // carry ripples through every chunk
      do_op(av, bv, "b2b");
      drain("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
